// File: rtl/axis_frame_writer.sv
// axis_frame_writer: converts an AXI4-Stream video beat stream into registered
// framebuffer write strobes (address, data, enable). Aligns on start-of-frame
// (TUSER), checks end-of-line (TLAST) against the configured geometry,
// resynchronises after errors and reports sticky status flags.
module axis_frame_writer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_axis_video_TVALID,
  output logic              s_axis_video_TREADY,
  input  logic [DATA_W-1:0] s_axis_video_TDATA,
  input  logic              s_axis_video_TUSER,
  input  logic              s_axis_video_TLAST,
  output logic [ADDR_W-1:0] pxl_addr_o,
  output logic [DATA_W-1:0] pxl_data_o,
  output logic              pxl_en_o,
  output logic              frame_done_o,
  output logic              locked_o,
  output logic [15:0]       frame_cnt_o,
  output logic              sof_err_o,
  output logic              eol_early_o,
  output logic              eol_late_o,
  input  logic              err_clr_i
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0]     X_LAST    = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ready_q;

  logic              beat;
  logic              at_origin;
  logic              resync;
  logic              line_end;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              frame_end_d;
  logic              set_sof, set_early, set_late;

  assign beat                = s_axis_video_TVALID & ready_q;
  assign at_origin           = (x_q == '0) && (y_q == '0);
  assign s_axis_video_TREADY = ready_q;
  assign locked_o            = (state_q != HUNT);

  // Next-state, counter and write-strobe decode for the accepted beat.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = base_q + ADDR_W'(x_q);
    frame_end_d = 1'b0;
    resync      = 1'b0;
    line_end    = 1'b0;
    set_sof     = 1'b0;
    set_early   = 1'b0;
    set_late    = 1'b0;

    case (state_q)
      HUNT: begin
        // Only a start-of-frame beat can bring the writer into alignment.
        if (beat && s_axis_video_TUSER) resync = 1'b1;
      end

      ACTIVE: begin
        if (beat) begin
          if (s_axis_video_TUSER) begin
            set_sof = !at_origin;
            resync  = 1'b1;
          end else if (at_origin) begin
            // A new frame must open with TUSER; drop the beat and realign.
            set_sof = 1'b1;
            state_d = HUNT;
          end else begin
            wr_en_d = 1'b1;
            if (s_axis_video_TLAST) begin
              set_early = (x_q != X_LAST);
              line_end  = 1'b1;
            end else if (x_q == X_LAST) begin
              // Line overran: keep this pixel, then skip to the real TLAST.
              set_late = 1'b1;
              state_d  = DISCARD;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end

      DISCARD: begin
        if (beat) begin
          if (s_axis_video_TUSER) begin
            set_sof = 1'b1;
            resync  = 1'b1;
          end else if (s_axis_video_TLAST) begin
            line_end = 1'b1;
            state_d  = ACTIVE;
          end
        end
      end

      default: state_d = HUNT;
    endcase

    // Start-of-frame beat always lands at address 0 and restarts the counters.
    if (resync) begin
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      x_d       = XW'(1);
      y_d       = '0;
      base_d    = '0;
      state_d   = ACTIVE;
    end

    // Line end advances to the next line, or wraps at the frame boundary.
    if (line_end) begin
      x_d = '0;
      if (y_q == Y_LAST) begin
        frame_end_d = 1'b1;
        y_d         = '0;
        base_d      = '0;
      end else begin
        y_d    = y_q + 1'b1;
        base_d = base_q + LINE_STEP;
      end
    end
  end

  // State register and position counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q <= HUNT;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
    end
  end

  // Ready rises on the first clock out of reset and then stays high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // Registered write port; address and data hold while the strobe is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pxl_en_o     <= 1'b0;
      pxl_addr_o   <= '0;
      pxl_data_o   <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      pxl_en_o     <= wr_en_d;
      frame_done_o <= frame_end_d;
      if (wr_en_d) begin
        pxl_addr_o <= wr_addr_d;
        pxl_data_o <= s_axis_video_TDATA;
      end
      if (frame_end_d) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

  // Sticky error flags: a new event wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sof_err_o   <= 1'b0;
      eol_early_o <= 1'b0;
      eol_late_o  <= 1'b0;
    end else begin
      sof_err_o   <= set_sof   | (sof_err_o   & ~err_clr_i);
      eol_early_o <= set_early | (eol_early_o & ~err_clr_i);
      eol_late_o  <= set_late  | (eol_late_o  & ~err_clr_i);
    end
  end

endmodule
